// File: rtl/floppy_multi_if.sv
// Controller-side bundle for the multi-drive floppy mechanism: drive select, motor, stepping, format config in; strobes/status out.
// Purely combinational wiring, no latency of its own.
// No backpressure: the mechanism free-runs and the controller samples dclk_en-qualified status.
interface floppy_multi_if #(
    parameter int DRIVES = 4
);
    // controller -> mechanism
    logic [DRIVES-1:0] select;
    logic              motor_on;
    logic              step_in;
    logic              step_out;
    logic [7:0]        step_delay_ms;
    logic [1:0]        density;
    logic [10:0]       sector_len;
    logic              sector_base;
    logic [4:0]        spt;
    logic [9:0]        sector_gap_len;
    logic [DRIVES-1:0] wp_in;
    // mechanism -> controller
    logic              dclk_en;
    logic [2:0]        drive_idx;
    logic [7:0]        track;
    logic [4:0]        sector;
    logic              sector_hdr;
    logic              sector_data;
    logic              ready;
    logic              index;
    logic              track0;
    logic              write_protect;

    modport master (
        output select, motor_on, step_in, step_out, step_delay_ms, density,
               sector_len, sector_base, spt, sector_gap_len, wp_in,
        input  dclk_en, drive_idx, track, sector, sector_hdr, sector_data,
               ready, index, track0, write_protect
    );

    modport slave (
        input  select, motor_on, step_in, step_out, step_delay_ms, density,
               sector_len, sector_base, spt, sector_gap_len, wp_in,
        output dclk_en, drive_idx, track, sector, sector_hdr, sector_data,
               ready, index, track0, write_protect
    );
endinterface

// File: rtl/floppy_multi.sv
// Multi-drive virtual floppy: shared spindle/byte clock, per-drive head position, busy timer and write-protect.
// Ports: clk, reset (sync, active-high), bus (floppy_multi_if.slave). dclk_en registered; track/status combinational from state.
// No backpressure: bytes stream at the density rate while the spindle turns; the controller must keep up.
module floppy_multi #(
    parameter int SYS_CLK        = 42578000,
    parameter int DRIVES         = 4,
    parameter int TRACKS         = 85,
    parameter int SPINUP_MS      = 250,
    parameter int SPINDOWN_MS    = 250,
    parameter int INDEX_MS       = 4,
    parameter int SECTOR_HDR_LEN = 6
) (
    input logic           clk,
    input logic           reset,
    floppy_multi_if.slave bus
);
    localparam int MS_DIV = SYS_CLK / 1000;
    localparam int MSW    = $clog2(MS_DIV + 1);

    typedef enum logic [1:0] {SP_STOPPED, SP_SPINUP, SP_RUN, SP_SPINDOWN} spin_t;
    typedef enum logic [1:0] {SF_GAP, SF_HDR, SF_DATA} sfld_t;

    // ---------------- free-running ms tick ----------------
    logic [MSW-1:0] ms_cnt_q;
    logic           ms_tick;
    assign ms_tick = (ms_cnt_q == MSW'(MS_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || ms_tick) ms_cnt_q <= '0;
        else                  ms_cnt_q <= ms_cnt_q + 1'b1;
    end

    // ---------------- drive selection ----------------
    logic       sel_valid;
    logic [2:0] sel_enc, drive_idx_q, cur_idx;

    assign sel_valid = |bus.select;

    // Downward scan so the lowest set bit ends up winning.
    always_comb begin
        sel_enc = '0;
        for (int i = DRIVES - 1; i >= 0; i--)
            if (bus.select[i]) sel_enc = 3'(i);
    end

    assign cur_idx = sel_valid ? sel_enc : drive_idx_q;

    always_ff @(posedge clk) begin
        if (reset) drive_idx_q <= '0;
        else       drive_idx_q <= cur_idx;
    end

    // ---------------- stepping ----------------
    logic [7:0] trk_q  [DRIVES];
    logic [7:0] busy_q [DRIVES];
    logic       step_in_q, step_out_q, rise_in, rise_out;

    // Edge history follows the pins even through reset, so a line held
    // high across reset is not mistaken for a fresh edge afterwards.
    always_ff @(posedge clk) begin
        step_in_q  <= bus.step_in;
        step_out_q <= bus.step_out;
    end

    assign rise_in  = bus.step_in  & ~step_in_q  & sel_valid;
    assign rise_out = bus.step_out & ~step_out_q & sel_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DRIVES; i++) begin
                trk_q[i]  <= '0;
                busy_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DRIVES; i++) begin
                if ((rise_in || rise_out) && sel_enc == 3'(i)) begin
                    // Any accepted edge (even a saturated or cancelling one) restarts settle time.
                    busy_q[i] <= bus.step_delay_ms;
                    if (rise_in && !rise_out && trk_q[i] != 8'd0)
                        trk_q[i] <= trk_q[i] - 8'd1;
                    else if (rise_out && !rise_in && trk_q[i] < 8'(TRACKS - 1))
                        trk_q[i] <= trk_q[i] + 8'd1;
                end else if (ms_tick && busy_q[i] != 8'd0) begin
                    busy_q[i] <= busy_q[i] - 8'd1;
                end
            end
        end
    end

    logic [7:0] trk_sel, busy_sel;
    logic       wp_sel;
    always_comb begin
        trk_sel  = '0;
        busy_sel = '0;
        wp_sel   = 1'b0;
        for (int i = 0; i < DRIVES; i++) begin
            if (cur_idx == 3'(i)) begin
                trk_sel  = trk_q[i];
                busy_sel = busy_q[i];
                wp_sel   = bus.wp_in[i];
            end
        end
    end

    // ---------------- spindle ----------------
    spin_t       spin_q;
    logic [15:0] spin_tmr_q;
    logic        mon, spinning;

    assign mon      = bus.motor_on & sel_valid;
    assign spinning = (spin_q == SP_RUN) || (spin_q == SP_SPINDOWN);

    always_ff @(posedge clk) begin
        if (reset) begin
            spin_q     <= SP_STOPPED;
            spin_tmr_q <= '0;
        end else begin
            case (spin_q)
                SP_STOPPED:
                    if (mon) begin
                        spin_q     <= SP_SPINUP;
                        spin_tmr_q <= 16'(SPINUP_MS);
                    end
                SP_SPINUP:
                    if (!mon)                 spin_q     <= SP_STOPPED;
                    else if (spin_tmr_q == 0) spin_q     <= SP_RUN;
                    else if (ms_tick)         spin_tmr_q <= spin_tmr_q - 16'd1;
                SP_RUN:
                    if (!mon) begin
                        spin_q     <= SP_SPINDOWN;
                        spin_tmr_q <= 16'(SPINDOWN_MS);
                    end
                SP_SPINDOWN:
                    if (mon)                  spin_q     <= SP_RUN;
                    else if (spin_tmr_q == 0) spin_q     <= SP_STOPPED;
                    else if (ms_tick)         spin_tmr_q <= spin_tmr_q - 16'd1;
                default: spin_q <= SP_STOPPED;
            endcase
        end
    end

    // ---------------- byte clock ----------------
    logic [31:0] rate;
    logic [15:0] bpt;
    always_comb begin
        case (bus.density)
            2'd0:    begin rate = 32'd15625; bpt = 16'd3125;  end
            2'd1:    begin rate = 32'd31250; bpt = 16'd6250;  end
            default: begin rate = 32'd62500; bpt = 16'd12500; end
        endcase
    end

    // Fractional accumulator: one strobe each time acc crosses SYS_CLK.
    logic [31:0] acc_q;
    logic [32:0] acc_d;
    logic        dclk_q;
    assign acc_d = {1'b0, acc_q} + {1'b0, rate};

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            dclk_q <= 1'b0;
        end else if (spinning) begin
            if (acc_d >= 33'(SYS_CLK)) begin
                acc_q  <= 32'(acc_d - 33'(SYS_CLK));
                dclk_q <= 1'b1;
            end else begin
                acc_q  <= acc_d[31:0];
                dclk_q <= 1'b0;
            end
        end else begin
            dclk_q <= 1'b0;
        end
    end

    // ---------------- rotation and sector framing ----------------
    logic [15:0] byte_cnt_q, idx_tmr_q;
    sfld_t       sf_q;
    logic [10:0] fld_cnt_q, fld_len;
    logic [4:0]  sector_q;
    logic [5:0]  last_sector;
    logic        wrap, fld_done;

    // ">=" lets a shrink in BPT (density change) wrap on the very next byte.
    assign wrap = dclk_q && (byte_cnt_q >= bpt - 16'd1);

    always_comb begin
        case (sf_q)
            SF_GAP:  fld_len = {1'b0, bus.sector_gap_len};
            SF_HDR:  fld_len = 11'(SECTOR_HDR_LEN);
            default: fld_len = bus.sector_len;
        endcase
    end

    assign fld_done    = ({1'b0, fld_cnt_q} + 12'd1) >= {1'b0, fld_len};
    assign last_sector = {5'd0, bus.sector_base} + {1'b0, bus.spt} - 6'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q <= '0;
            idx_tmr_q  <= '0;
            sf_q       <= SF_GAP;
            fld_cnt_q  <= '0;
            sector_q   <= {4'd0, bus.sector_base};
        end else begin
            if (wrap)
                idx_tmr_q <= 16'(INDEX_MS);
            else if (ms_tick && idx_tmr_q != 16'd0)
                idx_tmr_q <= idx_tmr_q - 16'd1;

            if (wrap) begin
                byte_cnt_q <= '0;
                sf_q       <= SF_GAP;
                fld_cnt_q  <= '0;
                sector_q   <= {4'd0, bus.sector_base};
            end else if (dclk_q) begin
                byte_cnt_q <= byte_cnt_q + 16'd1;
                if (fld_done) begin
                    fld_cnt_q <= '0;
                    case (sf_q)
                        SF_GAP:  sf_q <= SF_HDR;
                        SF_HDR:  sf_q <= SF_DATA;
                        default: begin
                            sf_q <= SF_GAP;
                            if ({1'b0, sector_q} >= last_sector)
                                sector_q <= {4'd0, bus.sector_base};
                            else
                                sector_q <= sector_q + 5'd1;
                        end
                    endcase
                end else begin
                    fld_cnt_q <= fld_cnt_q + 11'd1;
                end
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.dclk_en       = dclk_q;
    assign bus.drive_idx     = cur_idx;
    assign bus.track         = trk_sel;
    assign bus.sector        = sector_q;
    assign bus.sector_hdr    = (sf_q == SF_HDR);
    assign bus.sector_data   = (sf_q == SF_DATA);
    assign bus.ready         = sel_valid && (spin_q == SP_RUN) && (busy_sel == 8'd0);
    assign bus.index         = (idx_tmr_q != 16'd0);
    assign bus.track0        = sel_valid && (trk_sel == 8'd0);
    assign bus.write_protect = sel_valid && wp_sel;
endmodule

// File: tb/tb_floppy_multi.sv
// Self-checking bench for floppy_multi with a scaled clock (100 clocks per ms) and a behavioural model.
// Inputs are applied 1 unit after posedge; outputs are sampled away from the edge.
// Byte stream and spindle are free-running; the bench only observes them.
module tb_floppy_multi;
    localparam int SYS_CLK = 100000;
    localparam int DRV     = 4;
    localparam int TRK     = 8;
    localparam int SPUP    = 5;
    localparam int SPDN    = 5;
    localparam int IDXMS   = 4;
    localparam int HDRLEN  = 6;
    localparam int GAP     = 40;
    localparam int SLEN    = 256;
    localparam int SPT     = 18;
    localparam int BASE    = 1;
    localparam int BPT_DD  = 6250;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    floppy_multi_if #(.DRIVES(DRV)) bus ();

    floppy_multi #(
        .SYS_CLK(SYS_CLK), .DRIVES(DRV), .TRACKS(TRK), .SPINUP_MS(SPUP),
        .SPINDOWN_MS(SPDN), .INDEX_MS(IDXMS), .SECTOR_HDR_LEN(HDRLEN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model of heads / selection ----------------
    int m_trk[DRV];
    int m_idx  = 0;
    bit m_pin  = 0;
    bit m_pout = 0;
    bit m_run  = 0;
    bit chk_rdy = 0;

    function automatic int lowest(input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) return i;
        return -1;
    endfunction

    // One clock of stimulus: check combinational status against the model,
    // then let the edge happen and apply the specification's stepping rules.
    task automatic cyc(input logic [3:0] sel, input logic si, input logic so, input logic [3:0] wp);
        int lo, e;
        bit rin, rout;
        bus.select = sel; bus.step_in = si; bus.step_out = so; bus.wp_in = wp;
        #2;
        lo = lowest(sel);
        e  = (lo >= 0) ? lo : m_idx;
        chk("drive_idx", int'(bus.drive_idx), e);
        chk("track", int'(bus.track), m_trk[e]);
        chk("track0", int'(bus.track0), int'(lo >= 0 && m_trk[e] == 0));
        chk("write_protect", int'(bus.write_protect), (lo >= 0) ? int'(wp[e]) : 0);
        if (chk_rdy) chk("ready", int'(bus.ready), int'(lo >= 0 && m_run));
        @(posedge clk);
        if (lo >= 0) begin
            rin  = si && !m_pin;
            rout = so && !m_pout;
            if (rin && !rout && m_trk[lo] > 0)       m_trk[lo]--;
            if (rout && !rin && m_trk[lo] < TRK - 1) m_trk[lo]++;
            m_idx = lo;
        end
        m_pin = si; m_pout = so;
        m_run = (lo >= 0);   // motor held on; deselect gaps are far shorter than spin-down
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt, last, mn, mx, k, rises, rise_t, w;
        bit synced, prev_idx;

        for (int i = 0; i < DRV; i++) m_trk[i] = 0;
        reset = 1'b1;
        bus.select = '0; bus.motor_on = 1'b0; bus.step_in = 1'b0; bus.step_out = 1'b0;
        bus.step_delay_ms = 8'd0; bus.density = 2'd1; bus.sector_len = 11'(SLEN);
        bus.sector_base = 1'(BASE); bus.spt = 5'(SPT); bus.sector_gap_len = 10'(GAP);
        bus.wp_in = 4'b1111;

        // ---------------- reset values ----------------
        tick(3);
        chk("rst_dclk_en", int'(bus.dclk_en), 0);
        chk("rst_ready", int'(bus.ready), 0);
        chk("rst_index", int'(bus.index), 0);
        chk("rst_sector_hdr", int'(bus.sector_hdr), 0);
        chk("rst_sector_data", int'(bus.sector_data), 0);
        chk("rst_track0", int'(bus.track0), 0);
        chk("rst_write_protect", int'(bus.write_protect), 0);
        chk("rst_drive_idx", int'(bus.drive_idx), 0);
        chk("rst_track", int'(bus.track), 0);
        chk("rst_sector", int'(bus.sector), BASE);
        reset = 1'b0;
        bus.wp_in = '0;
        tick(1);

        // ---------------- spin-up ----------------
        bus.motor_on = 1'b1;
        bus.select   = 4'b0001;
        n = 0;
        while (!bus.ready && n < 2000) begin tick(1); n++; end
        chk("spinup_within_1ms", int'(n >= (SPUP - 1) * 100 && n <= (SPUP + 1) * 100), 1);
        m_run = 1;

        // ---------------- DD byte strobe spacing ----------------
        cnt = 0; last = -1; mn = 1000; mx = 0;
        for (int c = 0; c < 3200; c++) begin
            tick(1);
            if (bus.dclk_en) begin
                if (last >= 0) begin
                    if (c - last < mn) mn = c - last;
                    if (c - last > mx) mx = c - last;
                end
                last = c; cnt++;
            end
        end
        chk("dclk_min_gap", mn, 3);
        chk("dclk_max_gap", mx, 4);
        chk("dclk_rate_1000_per_3200", int'(cnt >= 999 && cnt <= 1001), 1);

        // ---------------- stepping and settle time ----------------
        bus.step_delay_ms = 8'd6;
        cyc(4'b0001, 0, 1, 0); cyc(4'b0001, 0, 0, 0);
        cyc(4'b0001, 0, 1, 0); cyc(4'b0001, 0, 0, 0);
        cyc(4'b0001, 0, 1, 0);
        chk("ready_drops_after_step", int'(bus.ready), 0);
        chk("track_after_3_steps", int'(bus.track), 3);
        n = 0;
        while (!bus.ready && n < 2000) begin tick(1); n++; end
        chk("busy_6ms_within_1ms", int'(n >= 500 && n <= 700), 1);
        cyc(4'b0001, 0, 0, 0);
        cyc(4'b0010, 1, 0, 0);      // step_in on drive 1, already at track 0
        chk("sat_step_in_busy", int'(bus.ready), 0);
        chk("sat_step_in_track0", int'(bus.track0), 1);
        chk("sat_step_in_track", int'(bus.track), 0);
        cyc(4'b0010, 0, 0, 0);
        tick(800);
        bus.step_delay_ms = 8'd0;
        chk_rdy = 1;

        // ---------------- per-drive head positions ----------------
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0100, 0, 1, 4'b0100);
            cyc(4'b0100, 0, 0, 4'b0100);
        end
        cyc(4'b0001, 0, 0, 4'b0100);
        cyc(4'b0100, 0, 0, 4'b0100);
        cyc(4'b0110, 0, 0, 4'b0100);
        cyc(4'b0000, 0, 0, 4'b0100);
        cyc(4'b0100, 0, 0, 4'b0100);

        // ---------------- randomized select / step / write-protect ----------------
        for (int i = 0; i < 1500; i++)
            cyc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        cyc(4'b0001, 0, 0, 0);
        cyc(4'b0001, 0, 0, 0);
        chk_rdy = 0;

        // ---------------- rotation and sector framing ----------------
        // k = bytes consumed since index; field/sector follow from plain arithmetic.
        k = 0; synced = 0; rises = 0; rise_t = 0; prev_idx = 0;
        for (int t = 0; t < 45000 && rises < 2; t++) begin
            @(negedge clk);
            if (bus.index && !prev_idx) begin
                if (synced) chk("bytes_per_rev", k, BPT_DD);
                synced = 1; rises++; k = 0; rise_t = t;
            end
            if (!bus.index && prev_idx && synced) begin
                w = t - rise_t;
                chk("index_width_4ms", int'(w >= (IDXMS - 1) * 100 && w <= IDXMS * 100 + 1), 1);
            end
            prev_idx = bus.index;
            if (synced) begin
                int off, s;
                off = k % (GAP + HDRLEN + SLEN);
                s   = k / (GAP + HDRLEN + SLEN);
                chk("sector_hdr", int'(bus.sector_hdr), int'(off >= GAP && off < GAP + HDRLEN));
                chk("sector_data", int'(bus.sector_data), int'(off >= GAP + HDRLEN));
                chk("sector_num", int'(bus.sector), BASE + (s % SPT));
            end
            if (bus.dclk_en) k++;
        end
        chk("index_seen_twice", rises, 2);
        @(posedge clk); #1;

        // ---------------- spin-down ----------------
        bus.motor_on = 1'b0;
        tick(1);
        chk("ready_off_at_once", int'(bus.ready), 0);
        cnt = 0;
        for (int c = 0; c < 300; c++) begin tick(1); if (bus.dclk_en) cnt++; end
        chk("dclk_during_spindown", int'(cnt > 80), 1);
        bus.motor_on = 1'b1;
        tick(1);
        chk("resume_no_spinup", int'(bus.ready), 1);
        bus.motor_on = 1'b0;
        last = -1;
        for (int c = 1; c <= 1000; c++) begin tick(1); if (bus.dclk_en) last = c; end
        chk("spindown_5ms_within_1ms", int'(last >= (SPDN - 1) * 100 && last <= (SPDN + 1) * 100), 1);
        chk("stopped_ready", int'(bus.ready), 0);

        // ---------------- reset with a step edge in the same cycle ----------------
        bus.motor_on = 1'b1;
        tick(700);
        bus.step_delay_ms = 8'd3;
        bus.step_out = 1'b1;
        reset = 1'b1;
        tick(1);
        chk("rst2_track", int'(bus.track), 0);
        chk("rst2_track0", int'(bus.track0), 1);
        chk("rst2_sector", int'(bus.sector), BASE);
        chk("rst2_hdr", int'(bus.sector_hdr), 0);
        chk("rst2_data", int'(bus.sector_data), 0);
        chk("rst2_dclk", int'(bus.dclk_en), 0);
        chk("rst2_ready", int'(bus.ready), 0);
        chk("rst2_index", int'(bus.index), 0);
        reset = 1'b0;
        tick(2);
        chk("rst2_no_step_after", int'(bus.track), 0);
        bus.select = 4'b0100;
        #1;
        chk("rst2_drive2_track", int'(bus.track), 0);
        chk("rst2_drive_idx", int'(bus.drive_idx), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/floppy_multi.md
# floppy_multi

Parametrised multi-drive virtual floppy mechanism for the FD1771 controller path. Emulates DRIVES drives sharing one motor line and one spindle timebase, each with its own head position, step-busy timer and write-protect state. Produces the byte-clock enable, index pulse and sector header/data framing the controller uses to gate transfers to the CPU. It replaces the single-drive model and adds drive multiplexing, configurable step rate and spin-down timing, track-0 and write-protect status, and synchronous reset.

## Interface
- SYS_CLK, 42578000, system clock frequency in Hz
- DRIVES, 4, number of emulated drives (1..8)
- TRACKS, 85, tracks per drive; the head saturates at TRACKS-1
- SPINUP_MS, 250, delay from motor on to full speed
- SPINDOWN_MS, 250, delay from motor off to stopped
- INDEX_MS, 4, index pulse width
- SECTOR_HDR_LEN, 6, header bytes per sector

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- select  in  DRIVES  one-hot drive select; if several bits are set, the lowest index wins
- motor_on  in  1  shared motor line
- step_in  in  1  rising edge moves the head one track toward track 0
- step_out  in  1  rising edge moves the head one track outward
- step_delay_ms  in  8  head settle time per step, in ms
- density  in  2  0=SD 125 kbit/s, 1=DD 250 kbit/s, 2/3=HD 500 kbit/s
- sector_len  in  11  data bytes per sector
- sector_base  in  1  number of the first sector on a track
- spt  in  5  sectors per track
- sector_gap_len  in  10  gap bytes before each header
- wp_in  in  DRIVES  per-drive write-protect
- dclk_en  out  1  one-cycle byte strobe
- drive_idx  out  3  index of the selected drive
- track  out  8  track of the selected drive
- sector  out  5  sector currently under the head
- sector_hdr, sector_data  out  1  head is over header / data bytes
- ready  out  1  selected, at speed, not stepping
- index  out  1  index pulse, active-high
- track0  out  1  selected drive is on track 0
- write_protect  out  1  wp_in of the selected drive; 0 when no drive is selected

## Operation
- ms tick: a free-running counter wraps every SYS_CLK/1000 clocks and emits a one-cycle tick. All ms timers decrement only on the tick.
- Drive selection: sel_valid = |select. drive_idx is the priority encode of select and holds its last value while sel_valid=0.
- Stepping:
  - Edge detectors on step_in and step_out are always registered.
  - An edge is acted on only if sel_valid=1, and only on the selected drive.
  - step_in saturates at 0; step_out saturates at TRACKS-1.
  - Every accepted edge, including a saturated one, loads busy[drive_idx] with step_delay_ms. This reloads the timer if it is already running.
  - Rising edges on step_in and step_out in the same cycle: the track is unchanged and busy is loaded.
  - Each drive's busy timer decrements on the tick until it reaches 0.
- Spindle FSM, states STOPPED, SPINUP, RUN, SPINDOWN. The condition is mon = motor_on & sel_valid.
  - STOPPED: mon=1 loads SPINUP_MS and goes to SPINUP.
  - SPINUP: the timer reaches 0 -> RUN; mon=0 -> STOPPED.
  - RUN: mon=0 loads SPINDOWN_MS and goes to SPINDOWN.
  - SPINDOWN: mon=1 -> RUN with no delay; the timer reaches 0 -> STOPPED.
  - spinning = (state is RUN or SPINDOWN).
- Byte clock:
  - Rate R = 15625, 31250 or 62500 bytes/s per density.
  - While spinning: acc += R each cycle; when acc+R >= SYS_CLK, acc <= acc+R-SYS_CLK and dclk_en=1.
  - acc is 32-bit and is held while not spinning.
- Rotation:
  - byte_cnt counts dclk_en over BPT = 3125, 6250 or 12500 bytes per density.
  - On the wrap to 0, index is asserted for INDEX_MS ticks and the sector FSM restarts.
  - A density change takes effect at the next wrap. If byte_cnt is already >= the new BPT, it wraps on the next dclk_en.
- Sector FSM, advanced on dclk_en:
  - GAP(sector_gap_len) -> HDR(SECTOR_HDR_LEN) -> DATA(sector_len) -> GAP.
  - sector starts at sector_base and increments after each DATA. After sector_base+spt-1 it returns to sector_base.
  - An index wrap forces GAP with a full count and sector=sector_base.
- ready = sel_valid & (state==RUN) & (busy[drive_idx]==0).
- track0 = sel_valid & (track==0).

## Timing
- Values after reset:
  - Every track is 0 and every busy timer is 0.
  - The spindle is in STOPPED; acc, byte_cnt and the ms counter are 0.
  - The sector FSM is in GAP with sector=sector_base.
  - All outputs are 0 except sector and track.
- A reset during any operation takes effect on the next clock edge. It overrides every other event, including step edges in the same cycle.
- Output latency:
  - track, track0 and write_protect are combinational from registered state and select.
  - A step edge is sampled at cycle n; track updates at n+1 and ready drops at n+1.
  - dclk_en is registered and lasts exactly one cycle. There is never more than one dclk_en per cycle.
- sector_hdr and sector_data change on the cycle after the dclk_en that closes the previous field.
- Timing uncertainty:
  - SPINUP and busy timers expire within 1 ms of the nominal value, because the ms tick is free-running.
  - index width is exactly INDEX_MS ticks.

## Test plan
- Reset, select=0001, motor_on=1 -> ready goes 1 between 249 and 251 ms later; then dclk_en fires every 1362 or 1363 clocks (DD).
- Drive 0 at track 0, three step_out edges with step_delay_ms=6 -> track=3; ready is 0 until 6 ms (within 1 ms) after the last edge. A step_in at track 0 -> track stays 0, busy is loaded, track0=1.
- Step drive 2 to track 5, then select=0001 -> track=0 and drive_idx=0; reselect drive 2 -> track=5. select=0110 -> drive_idx=1.
- DD, spt=18, sector_len=256, sector_gap_len=40, sector_base=1 -> index high for 4 ms every 6250 dclk_en; sector_hdr first after 40 bytes; sector 18 is followed by sector 1.
- motor_on 1->0 in RUN -> ready=0 immediately and dclk_en continues for 250 ms; motor_on back to 1 at 100 ms -> RUN with no spin-up delay.
- Assert reset mid-sector with a step edge in the same cycle -> all state returns to reset values and the track is not incremented.
